// File: rtl/riscv_pkg.sv
// Shared definitions for the FPU hazard scoreboard: register index width,
// register-file selectors and the FDIV/FSQRT sequencer state encoding.
package riscv_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic FILE_X = 1'b0;
  localparam logic FILE_F = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_BUSY    = 2'd1,
    DIV_DONE    = 2'd2,
    DIV_WAIT_WB = 2'd3
  } div_state_e;

endpackage

// File: rtl/sb_regfile_bits.sv
// Busy bits for one register file: one set and one clear port per cycle,
// three source read ports plus a destination read port. HARD_ZERO pins entry 0 idle.
module sb_regfile_bits
  import riscv_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter bit          HARD_ZERO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rs3_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic [2:0]           rs_busy,
  output logic                 rd_busy
);

  logic [NREG-1:0] busy_q, busy_d;

  // Clear is applied first so a same-index set in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en && !(HARD_ZERO && (set_idx == '0))) busy_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rs_busy = {busy_q[rs3_idx], busy_q[rs2_idx], busy_q[rs1_idx]};
  assign rd_busy = busy_q[rd_idx];

endmodule

// File: rtl/fpu_hazard_scoreboard.sv
// Issue-side scoreboard for long-latency writes to x/f files plus FDIV/FSQRT sequencer.
// Optional stall cycle counter enabled by defining SB_STALL_CNT_EN.
module fpu_hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned DIV_LAT = 12,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rs3,
  input  logic [2:0]           id_src_f,
  input  logic [2:0]           id_src_use,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_rd_f,
  input  logic                 id_reg_write,
  input  logic                 id_long,
  input  logic                 id_div,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_rd_f,
  output logic                 stall,
  output logic                 issue,
  output logic                 div_busy,
  output logic                 div_done
`ifdef SB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_count
`endif
);

  localparam int unsigned DCNT_W = $clog2(DIV_LAT);

  logic [2:0] x_rs_busy, f_rs_busy;
  logic       x_rd_busy, f_rd_busy;
  logic       set_en;
  logic       raw, waw, strct;

  div_state_e             state_q, state_d;
  logic [DCNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_IDX_W:0]     dest_q, dest_d;

  assign set_en = issue & id_long & id_reg_write;

  sb_regfile_bits #(.NREG(NREG), .HARD_ZERO(1'b1)) u_bits_x (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en & (id_rd_f == FILE_X)),
    .set_idx (id_rd),
    .clr_en  (wb_valid & (wb_rd_f == FILE_X)),
    .clr_idx (wb_rd),
    .rs1_idx (id_rs1),
    .rs2_idx (id_rs2),
    .rs3_idx (id_rs3),
    .rd_idx  (id_rd),
    .rs_busy (x_rs_busy),
    .rd_busy (x_rd_busy)
  );

  sb_regfile_bits #(.NREG(NREG), .HARD_ZERO(1'b0)) u_bits_f (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en & (id_rd_f == FILE_F)),
    .set_idx (id_rd),
    .clr_en  (wb_valid & (wb_rd_f == FILE_F)),
    .clr_idx (wb_rd),
    .rs1_idx (id_rs1),
    .rs2_idx (id_rs2),
    .rs3_idx (id_rs3),
    .rd_idx  (id_rd),
    .rs_busy (f_rs_busy),
    .rd_busy (f_rd_busy)
  );

  // Hazards are evaluated from registered state only; no WB bypass.
  always_comb begin
    raw = 1'b0;
    for (int unsigned s = 0; s < 3; s++) begin
      if (id_src_use[s]) raw = raw | (id_src_f[s] ? f_rs_busy[s] : x_rs_busy[s]);
    end
    waw   = id_reg_write & (id_rd_f ? f_rd_busy : x_rd_busy);
    strct = id_div & (state_q != DIV_IDLE);
    stall = ~reset & id_valid & ~flush & (raw | waw | strct);
    issue = ~reset & id_valid & ~flush & ~stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (issue && id_div) begin
          state_d = DIV_BUSY;
          cnt_d   = DCNT_W'(DIV_LAT - 1);
          dest_d  = {id_rd_f, id_rd};
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q - DCNT_W'(1);
        if (cnt_q == DCNT_W'(1)) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_WAIT_WB;
      DIV_WAIT_WB: begin
        if (wb_valid && ({wb_rd_f, wb_rd} == dest_q)) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    div_busy = (state_q != DIV_IDLE);
    div_done = (state_q == DIV_DONE);
  end

`ifdef SB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
